// File: rtl/pc_gen.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Next-PC priority: reset, redirect, stall, BTB prediction, sequential.
module pc_gen #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          BTB_DEPTH = 16,
   parameter int          STALL_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_signal,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   input  logic               update_valid,
   input  logic [XLEN-1:0]    update_pc,
   input  logic [XLEN-1:0]    update_target,
   input  logic               update_taken,
   output logic [XLEN-1:0]    pc,
   output logic               pred_taken,
   output logic [XLEN-1:0]    pred_target
);

   localparam int IDX   = $clog2(BTB_DEPTH);
   localparam int TAG_W = XLEN - IDX - 2;

   logic              btb_valid  [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag    [BTB_DEPTH];
   logic [XLEN-1:0]   btb_target [BTB_DEPTH];
   logic [1:0]        btb_ctr    [BTB_DEPTH];

   logic [IDX-1:0]    fetch_idx;
   logic [TAG_W-1:0]  fetch_tag;
   logic [IDX-1:0]    upd_idx;
   logic [TAG_W-1:0]  upd_tag;
   logic              upd_hit;
   logic [XLEN-1:0]   pc_next;
   logic              unused_bits;

   assign unused_bits = ^{stall_signal[STALL_W-1:1], update_pc[1:0]};

   // Lookup reads pre-update contents; there is no bypass from the update port.
   assign fetch_idx   = pc[IDX+1:2];
   assign fetch_tag   = pc[XLEN-1:IDX+2];
   assign pred_taken  = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag)
                        && btb_ctr[fetch_idx][1];
   assign pred_target = btb_target[fetch_idx];

   assign upd_idx = update_pc[IDX+1:2];
   assign upd_tag = update_pc[XLEN-1:IDX+2];
   assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

   always_comb begin
      pc_next = pc + XLEN'(4);
      if (redirect_valid)
         pc_next = redirect_pc;
      else if (stall_signal[0])
         pc_next = pc;
      else if (pred_taken)
         pc_next = pred_target;
   end

   always_ff @(posedge clk) begin
      if (rst)
         pc <= XLEN'(RESET_PC);
      else
         pc <= pc_next;
   end

   // Stall does not gate training; a taken miss replaces whatever occupies the slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            btb_valid[i] <= 1'b0;
            btb_ctr[i]   <= 2'd0;
         end
      end else if (update_valid) begin
         if (upd_hit) begin
            if (update_taken) begin
               btb_target[upd_idx] <= update_target;
               if (btb_ctr[upd_idx] != 2'd3)
                  btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
            end else if (btb_ctr[upd_idx] != 2'd0) begin
               btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
            end
         end else if (update_taken) begin
            btb_valid[upd_idx]  <= 1'b1;
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= update_target;
            btb_ctr[upd_idx]    <= 2'd2;
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: sequencing, stall, redirect,
// BTB allocation/training/aliasing, wrap-around and reset behaviour.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  stall_signal;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        update_valid;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic        update_taken;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;

   int total = 0;
   int bad   = 0;

   pc_gen dut (
      .clk            (clk),
      .rst            (rst),
      .stall_signal   (stall_signal),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .update_valid   (update_valid),
      .update_pc      (update_pc),
      .update_target  (update_target),
      .update_taken   (update_taken),
      .pc             (pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [4:0] st,
                                input logic rv, input logic [31:0] rpc,
                                input logic uv, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic utk);
      rst            = r;
      stall_signal   = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      update_valid   = uv;
      update_pc      = upc;
      update_target  = utgt;
      update_taken   = utk;
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      #1;

      // Reset then sequential fetch
      tick();
      checkOutput("reset_pc", pc, 32'h0);
      checkOutput("reset_pred", {31'd0, pred_taken}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("seq_4", pc, 32'h4);
      checkOutput("seq_4_pred", {31'd0, pred_taken}, 32'd0);
      tick(); checkOutput("seq_8", pc, 32'h8);
      tick(); checkOutput("seq_c", pc, 32'hC);
      checkOutput("seq_c_pred", {31'd0, pred_taken}, 32'd0);

      // Stall on bit 0 holds; upper bits do nothing
      applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0);
      tick(); checkOutput("redir_10", pc, 32'h10);
      applyStimulus(0, 5'b00001, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("stall_1", pc, 32'h10);
      tick(); checkOutput("stall_2", pc, 32'h10);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("unstall", pc, 32'h14);
      applyStimulus(0, 5'b11110, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("upper_stall", pc, 32'h18);

      // Redirect beats stall
      applyStimulus(0, 5'b00001, 1, 32'h200, 0, 0, 0, 0);
      tick(); checkOutput("redir_over_stall", pc, 32'h200);

      // Allocate 0x20 -> 0x100, then fetch it
      applyStimulus(0, 0, 0, 0, 1, 32'h20, 32'h100, 1);
      tick(); checkOutput("alloc_seq", pc, 32'h204);
      applyStimulus(0, 0, 1, 32'h20, 0, 0, 0, 0);
      tick(); checkOutput("at_20", pc, 32'h20);
      checkOutput("pred_20", {31'd0, pred_taken}, 32'd1);
      checkOutput("tgt_20", pred_target, 32'h100);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("follow_pred", pc, 32'h100);

      // Two not-taken updates drive counter 2 -> 0
      applyStimulus(0, 0, 0, 0, 1, 32'h20, 32'h0, 0);
      tick(); checkOutput("nt1_seq", pc, 32'h104);
      tick(); checkOutput("nt2_seq", pc, 32'h108);
      applyStimulus(0, 0, 1, 32'h20, 0, 0, 0, 0);
      tick(); checkOutput("at_20_cold", pc, 32'h20);
      checkOutput("pred_20_cold", {31'd0, pred_taken}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("seq_24", pc, 32'h24);

      // Mid-stream reset, then aliasing at index 8
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("mid_reset_pc", pc, 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 32'h20, 32'h100, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 32'h60, 32'h300, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 32'hA0, 32'h700, 0);
      tick(); checkOutput("alias_seq", pc, 32'hC);
      applyStimulus(0, 0, 1, 32'h20, 0, 0, 0, 0);
      tick(); checkOutput("pred_20_evicted", {31'd0, pred_taken}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("seq_after_evict", pc, 32'h24);
      applyStimulus(0, 0, 1, 32'hA0, 0, 0, 0, 0);
      tick(); checkOutput("pred_a0", {31'd0, pred_taken}, 32'd0);
      applyStimulus(0, 0, 1, 32'h60, 0, 0, 0, 0);
      tick(); checkOutput("pred_60", {31'd0, pred_taken}, 32'd1);
      checkOutput("tgt_60", pred_target, 32'h300);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("follow_60", pc, 32'h300);

      // Update during the fetch cycle: no bypass, effect next cycle
      applyStimulus(0, 0, 1, 32'h40, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 32'h40, 32'h500, 1);
      checkOutput("nobypass_pred", {31'd0, pred_taken}, 32'd0);
      tick(); checkOutput("nobypass_pc", pc, 32'h44);
      applyStimulus(0, 0, 1, 32'h40, 0, 0, 0, 0);
      tick(); checkOutput("pred_40", {31'd0, pred_taken}, 32'd1);
      checkOutput("tgt_40", pred_target, 32'h500);

      // Stall beats prediction but training still happens
      applyStimulus(0, 5'b00001, 0, 0, 1, 32'h80, 32'h600, 1);
      tick(); checkOutput("stall_over_pred", pc, 32'h40);
      applyStimulus(0, 0, 1, 32'h80, 0, 0, 0, 0);
      tick(); checkOutput("pred_80", {31'd0, pred_taken}, 32'd1);
      checkOutput("tgt_80", pred_target, 32'h600);

      // Wrap-around
      applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      tick(); checkOutput("at_top", pc, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("wrap", pc, 32'h0);

      // Reset overrides redirect and update
      applyStimulus(1, 5'b00001, 1, 32'h900, 1, 32'h20, 32'h100, 1);
      tick(); checkOutput("rst_override_pc", pc, 32'h0);
      applyStimulus(0, 0, 1, 32'h20, 0, 0, 0, 0);
      tick(); checkOutput("rst_no_alloc", {31'd0, pred_taken}, 32'd0);
      applyStimulus(0, 0, 1, 32'h40, 0, 0, 0, 0);
      tick(); checkOutput("rst_cleared_40", {31'd0, pred_taken}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); checkOutput("rst_cleared_seq", pc, 32'h44);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
